// File: rtl/fifo_b_pkg.sv
// Shared defaults and entry layout for the hit-info FIFO and the blocks that produce entries.
package fifo_b_pkg;

    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 64;
    localparam int FB_CNT_W  = 8;

    typedef struct packed {
        logic [FB_DATA_W-1:0] s;
        logic [FB_DATA_W-1:0] q;
        logic [FB_DATA_W-1:0] len;
    } entry_t;

    function automatic entry_t mk_entry(input logic [FB_DATA_W-1:0] s,
                                        input logic [FB_DATA_W-1:0] q,
                                        input logic [FB_DATA_W-1:0] len);
        entry_t e;
        e.s   = s;
        e.q   = q;
        e.len = len;
        return e;
    endfunction

endpackage

// File: rtl/fifo_b_mem.sv
// Entry storage: register array, one synchronous write port and one registered read port.
module fifo_b_mem
    import fifo_b_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [3*DATA_W-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [3*DATA_W-1:0] rdata
);

    logic [3*DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-before-write: a read and write to the same slot returns the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_b.sv
// Hit-info FIFO: {s, q, len} triples, zero-length writes filtered, pointer/count/flag control.
module fifo_b
    import fifo_b_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH,
    parameter int CNT_W  = FB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_s,
    input  logic [DATA_W-1:0] in_q,
    input  logic [DATA_W-1:0] in_len,
    output logic [DATA_W-1:0] out_s,
    output logic [DATA_W-1:0] out_q,
    output logic [DATA_W-1:0] out_len,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]       wptr, rptr;
    logic [CNT_W-1:0]    cnt;
    logic                rd_acc, wr_acc;
    logic [3*DATA_W-1:0] rdata;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (cnt == '0);
    assign full   = (cnt == CNT_W'(DEPTH));
    assign count  = cnt;

    // A concurrent read frees the slot, so a full FIFO still takes the write.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (in_len != '0) && (!full || rd_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (wr_acc) wptr <= ptr_inc(wptr);
            if (rd_acc) rptr <= ptr_inc(rptr);
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    fifo_b_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata ({in_s, in_q, in_len}),
        .re    (rd_acc),
        .raddr (rptr),
        .rdata (rdata)
    );

    assign {out_s, out_q, out_len} = rdata;

endmodule

// File: tb/tb_fifo_b.sv
// Directed bench for fifo_b with a queue model as scoreboard.
module tb_fifo_b;
    import fifo_b_pkg::*;

    localparam int DEPTH = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_s = '0, in_q = '0, in_len = '0;
    logic [7:0] out_s, out_q, out_len;
    logic       wr_en = 1'b0, rd_en = 1'b0;
    logic       empty, full;
    logic [7:0] count;

    int checks = 0;
    int failures = 0;

    entry_t mdl[$];
    entry_t exp_out = '0;

    always #5 clk = ~clk;

    fifo_b dut (
        .clk(clk), .reset(reset),
        .in_s(in_s), .in_q(in_q), .in_len(in_len),
        .out_s(out_s), .out_q(out_q), .out_len(out_len),
        .wr_en(wr_en), .rd_en(rd_en),
        .empty(empty), .full(full), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mdl.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(mdl.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(mdl.size() == DEPTH));
        chk({tag, ".out_s"},   32'(out_s),   32'(exp_out.s));
        chk({tag, ".out_q"},   32'(out_q),   32'(exp_out.q));
        chk({tag, ".out_len"}, 32'(out_len), 32'(exp_out.len));
    endtask

    // One clock: drive at negedge, update model, compare 1 time unit after the edge.
    task automatic step(input string tag, input logic wr, input logic rd,
                        input logic [7:0] s, input logic [7:0] q, input logic [7:0] len);
        bit rd_ok, wr_ok;
        @(negedge clk);
        wr_en = wr; rd_en = rd; in_s = s; in_q = q; in_len = len;
        rd_ok = rd && (mdl.size() != 0);
        wr_ok = wr && (len != 0) && ((mdl.size() < DEPTH) || rd_ok);
        if (rd_ok) exp_out = mdl.pop_front();
        if (wr_ok) mdl.push_back(mk_entry(s, q, len));
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        chk_all("rst");
        @(negedge clk);
        reset = 1'b1;
        step("idle", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        step("rd_empty", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);

        // Zero-length filter
        step("wr_len0", 1'b1, 1'b0, 8'd5, 8'd37, 8'd0);
        step("wr_len3", 1'b1, 1'b0, 8'd5, 8'd37, 8'd3);
        step("rd_len3", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);

        // Fill to full starting from pointer 1, so the walk wraps
        for (int i = 1; i <= DEPTH; i++)
            step("fill", 1'b1, 1'b0, 8'(i), 8'(255 - i), 8'(i));
        step("wr_drop", 1'b1, 1'b0, 8'hAA, 8'hBB, 8'd65);
        for (int i = 1; i <= DEPTH; i++)
            step("drain", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        step("rd_after_drain", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);

        // Simultaneous read/write while full
        for (int i = 1; i <= DEPTH; i++)
            step("fill2", 1'b1, 1'b0, 8'(i + 10), 8'(i), 8'(i));
        step("full_rw", 1'b1, 1'b1, 8'd9, 8'd8, 8'd99);
        chk("full_rw.len1", 32'(out_len), 32'd1);
        for (int i = 1; i <= DEPTH; i++)
            step("drain2", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        chk("drain2.last99", 32'(out_len), 32'd99);

        // Simultaneous read/write while empty
        step("empty_rw", 1'b1, 1'b1, 8'd1, 8'd2, 8'd7);
        chk("empty_rw.hold99", 32'(out_len), 32'd99);
        step("rd_len7", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        chk("rd_len7.len", 32'(out_len), 32'd7);

        // Asynchronous reset with entries stored
        for (int i = 1; i <= 10; i++)
            step("pre_rst", 1'b1, 1'b0, 8'(i), 8'(i), 8'(i + 20));
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        #2;
        reset = 1'b0;
        mdl.delete();
        exp_out = '0;
        #1;
        chk_all("async_rst");
        @(negedge clk);
        reset = 1'b1;
        step("rd_after_rst", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        step("wr_after_rst", 1'b1, 1'b0, 8'd3, 8'd4, 8'd5);
        step("rd_after_rst2", 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_b.md
FIFO_B -- requirements
Module: fifo_b

Interface
REQ-001 Parameter DATA_W, default 8: width of each of the three entry fields.
REQ-002 Parameter DEPTH, default 64: number of entries, power of two, at most 255.
REQ-003 Parameter CNT_W, default 8: width of the occupancy counter; SHALL satisfy 2^CNT_W > DEPTH.
REQ-004 Ports, in order:
- clk, input, 1 bit: the single clock; all state changes on its rising edge.
- reset, input, 1 bit: asynchronous, active-low reset.
- in_s, input, DATA_W bits: subject-address field of the write entry.
- in_q, input, DATA_W bits: query-address field of the write entry.
- in_len, input, DATA_W bits: hit-length field of the write entry.
- out_s, output, DATA_W bits: subject-address field of the last entry read.
- out_q, output, DATA_W bits: query-address field of the last entry read.
- out_len, output, DATA_W bits: hit-length field of the last entry read.
- wr_en, input, 1 bit: write request.
- rd_en, input, 1 bit: read request.
- empty, output, 1 bit: no entries stored.
- full, output, 1 bit: DEPTH entries stored.
- count, output, CNT_W bits: current number of stored entries.

Function
REQ-005 Each entry SHALL hold the triple {s, q, len}, stored and returned together, in first-in first-out order.
REQ-006 A write SHALL be accepted only when wr_en=1, in_len≠0, and the FIFO is not full or a read is accepted in the same cycle.
- A zero-length entry SHALL never be stored, since wr_en is normally tied high.
REQ-007 A read SHALL be accepted only when rd_en=1 and empty=0.
REQ-008 On an accepted read, out_s/out_q/out_len SHALL take the head entry at the clock edge, so data is valid one cycle after rd_en.
- Outputs SHALL hold their value when no read is accepted.
REQ-009 A read on an empty FIFO SHALL be ignored: pointers, count and outputs unchanged, no error.
REQ-010 A write on a full FIFO with no accepted read SHALL be dropped; stored contents unchanged.
REQ-011 Count update rules:
- Accepted write only: count +1.
- Accepted read only: count −1.
- Both accepted, or neither: count unchanged.
REQ-012 When read and write are both requested while empty, only the write SHALL take effect; the new entry is readable from the next cycle.
REQ-013 When read and write are both requested while full, both SHALL be accepted and full SHALL stay 1.
REQ-014 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH−1 to 0.
REQ-015 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH); both are registered-state derived with no combinational path from the inputs.

Reset
REQ-016 reset=0 SHALL asynchronously clear both pointers, count, out_s, out_q and out_len to 0, giving empty=1 and full=0.
REQ-017 A reset asserted mid-operation SHALL discard all stored entries.
- Storage array contents need not be cleared.
REQ-018 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Structure
REQ-019 A shared package SHALL hold DATA_W, CNT_W and DEPTH defaults plus an entry struct type {s, q, len}, for use by the hit-info producer blocks.
REQ-020 Storage SHALL be a separate sub-module fifo_b_mem: a DEPTH×(3·DATA_W) register array with one synchronous write port and one synchronous read port.
- Pointer, count and flag logic SHALL reside in fifo_b.

Verification
REQ-021 Reset then idle -> empty=1, full=0, count=0, all outputs 0; rd_en=1 on empty -> outputs remain 0 and count stays 0.
REQ-022 wr_en=1 with (s,q,len) = (5,37,0), then (5,37,3) -> only one entry stored, count=1; rd_en=1 -> next cycle out=(5,37,3), count=0, empty=1.
REQ-023 Write 64 entries with len=1..64 -> full=1 and count=64; a 65th write is dropped; 64 reads return len 1..64 in order, exercising pointer wrap.
REQ-024 At full, simultaneous rd_en and wr_en (len=99) -> out_len=1, count stays 64; after draining, the last entry read has len=99.
REQ-025 Empty FIFO with simultaneous rd_en and wr_en (len=7) -> outputs unchanged, count=1; next read returns len=7.
REQ-026 Assert reset with 10 entries stored -> count=0 and empty=1 immediately, without waiting for a clock edge; a subsequent read returns nothing new.
